// File: rtl/reflector_inverse.sv
// reflector_inverse: builds the inverse of the fixed Enigma reflector wiring
// into a register table after every reset. It then answers letter lookups over
// a valid/ready stream through a single output buffer.
// Optional build macro: REFL_INV_CHECK_EN enables two features:
//   - the out-of-range err flag, and
//   - the table self-check that can park the block in FAULT.
module reflector_inverse #(
  parameter int LETTERS = 26,
  parameter int W       = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_letter,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_letter,
  input  logic         out_ready,
  output logic         init_done,
  output logic         err
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam int          SLOTS = 1 << W;
  localparam logic [W-1:0] LAST = W'(LETTERS);

  state_t       state, state_nxt;
  logic [W-1:0] idx;
  logic [W-1:0] inv [0:SLOTS-1];
  logic [W-1:0] slot;
  logic         init_last;
  logic         accept;
  logic         drain;

  // Output buffer stage
  logic [W-1:0] letter_p1;
  logic         vld_p1;

  // Forward reflector wiring, letters 1..LETTERS; anything else maps to 0.
  function automatic logic [W-1:0] fwd_of(input logic [W-1:0] i);
    case (int'(i))
      1:       return W'(2);
      2:       return W'(18);
      3:       return W'(25);
      4:       return W'(7);
      5:       return W'(11);
      6:       return W'(8);
      7:       return W'(6);
      8:       return W'(5);
      9:       return W'(20);
      10:      return W'(14);
      11:      return W'(23);
      12:      return W'(4);
      13:      return W'(12);
      14:      return W'(9);
      15:      return W'(24);
      16:      return W'(21);
      17:      return W'(26);
      18:      return W'(17);
      19:      return W'(22);
      20:      return W'(10);
      21:      return W'(19);
      22:      return W'(1);
      23:      return W'(13);
      24:      return W'(3);
      25:      return W'(16);
      26:      return W'(15);
      default: return '0;
    endcase
  endfunction

  // A letter code is valid only in 1..LETTERS.
  function automatic logic in_range(input logic [W-1:0] l);
    return (l != '0) && (int'(l) <= LETTERS);
  endfunction

  assign slot      = fwd_of(idx);
  assign init_last = (state == INIT) && (idx == LAST);
  assign init_done = (state == RUN);
  assign in_ready  = (state == RUN) && (!vld_p1 || out_ready);
  assign accept    = in_valid && in_ready;
  assign drain     = vld_p1 && out_ready;

`ifdef REFL_INV_CHECK_EN
  logic [SLOTS-1:0] wr_mask;
  logic [SLOTS-1:0] wr_mask_nxt;
  logic             dup_seen;
  logic             dup_now;
  logic             init_bad;
  logic             err_p1;

  // Track which inverse slots the walk has written and flag any double write
  always_comb begin
    wr_mask_nxt = wr_mask;
    dup_now     = 1'b0;
    if (state == INIT) begin
      dup_now           = wr_mask[slot];
      wr_mask_nxt[slot] = 1'b1;
    end
    init_bad = dup_seen || dup_now || !(&wr_mask_nxt[LETTERS:1]);
  end

  // Self-check bookkeeping, cleared by reset so every rebuild is checked afresh
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_mask  <= '0;
      dup_seen <= 1'b0;
    end else if (state == INIT) begin
      wr_mask  <= wr_mask_nxt;
      dup_seen <= dup_seen || dup_now;
    end
  end

  // Out-of-range flag travels with the buffered result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_p1 <= 1'b0;
    end else if (accept) begin
      err_p1 <= !in_range(in_letter);
    end
  end

  assign err = err_p1;
`else
  assign err = 1'b0;
`endif

  // Next-state selection: INIT walks the wiring once, then RUN (or FAULT)
  always_comb begin
    state_nxt = state;
    case (state)
      INIT: begin
        if (init_last) begin
`ifdef REFL_INV_CHECK_EN
          state_nxt = init_bad ? FAULT : RUN;
`else
          state_nxt = RUN;
`endif
        end
      end
      RUN:     state_nxt = RUN;
      FAULT:   state_nxt = FAULT;
      default: state_nxt = INIT;
    endcase
  end

  // State register and build index; idx stops at LETTERS
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= INIT;
      idx   <= W'(1);
    end else begin
      state <= state_nxt;
      if ((state == INIT) && !init_last) begin
        idx <= idx + W'(1);
      end
    end
  end

  // Inverse table: one entry written per INIT cycle, inv[fwd[idx]] = idx
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SLOTS; k++) begin
        inv[k] <= '0;
      end
    end else if (state == INIT) begin
      inv[slot] <= idx;
    end
  end

  // Output buffer: load on accept, clear valid on a drain with no new load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      letter_p1 <= '0;
    end else if (accept) begin
      vld_p1    <= 1'b1;
      letter_p1 <= in_range(in_letter) ? inv[in_letter] : '0;
    end else if (drain) begin
      vld_p1    <= 1'b0;
    end
  end

  assign out_valid  = vld_p1;
  assign out_letter = letter_p1;

endmodule

// File: tb/tb_reflector_inverse.sv
// tb_reflector_inverse: scoreboard bench for reflector_inverse.
// Inputs change on the falling edge and outputs are sampled 1 ns later.
// Each test task starts and ends on a falling edge.
`timescale 1ns/1ps
module tb_reflector_inverse;

  localparam int W = 5;

`ifdef REFL_INV_CHECK_EN
  localparam logic ERR_OOR = 1'b1;
`else
  localparam logic ERR_OOR = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_letter;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_letter;
  logic         out_ready;
  logic         init_done;
  logic         err;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // scoreboard entries are {err, letter}
  logic [W:0] sb [$];

  int fwd [1:26] = '{2, 18, 25, 7, 11, 8, 6, 5, 20, 14, 23, 4, 12,
                     9, 24, 21, 26, 17, 22, 10, 19, 1, 13, 3, 16, 15};

  reflector_inverse dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_letter  (in_letter),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_letter (out_letter),
    .out_ready  (out_ready),
    .init_done  (init_done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] inv_of(input int l);
    for (int j = 1; j <= 26; j++) begin
      if (fwd[j] == l) return W'(j);
    end
    return '0;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_letter = W'(5); out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_letter !== '0) $display("FAIL reset_out_letter got %0d want 0", out_letter); else pass_cnt++;
    chk_cnt++; if (init_done !== 1'b0) $display("FAIL reset_init_done got %b want 0", init_done); else pass_cnt++;
    chk_cnt++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else pass_cnt++;
    rst_n = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      @(posedge clk); @(negedge clk); #1;
      chk_cnt++; if (init_done !== (e == 26)) $display("FAIL init_done_edge%0d got %b want %b", e, init_done, (e == 26)); else pass_cnt++;
      chk_cnt++; if (in_ready !== (e == 26)) $display("FAIL init_in_ready_edge%0d got %b want %b", e, in_ready, (e == 26)); else pass_cnt++;
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL init_out_valid_edge%0d got %b want 0", e, out_valid); else pass_cnt++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_lookup();
    int lets [5] = '{1, 2, 17, 22, 26};
    logic [W:0] e;
    for (int n = 0; n < 5; n++) begin
      in_valid = 1'b1; in_letter = W'(lets[n]); out_ready = 1'b1; #1;
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL lookup_in_ready letter %0d got %b want 1", lets[n], in_ready); else pass_cnt++;
      if (in_ready) sb.push_back({1'b0, inv_of(lets[n])});
      @(posedge clk); @(negedge clk); in_valid = 1'b0; #1;
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL lookup_latency letter %0d out_valid got %b want 1", lets[n], out_valid); else pass_cnt++;
      if (out_valid && sb.size() > 0) begin
        e = sb.pop_front();
        chk_cnt++; if (out_letter !== e[W-1:0]) $display("FAIL lookup_letter in %0d got %0d want %0d", lets[n], out_letter, e[W-1:0]); else pass_cnt++;
        chk_cnt++; if (err !== e[W]) $display("FAIL lookup_err in %0d got %b want %b", lets[n], err, e[W]); else pass_cnt++;
      end
      @(posedge clk); @(negedge clk); #1;
      chk_cnt++; if (out_valid !== 1'b0) $display("FAIL lookup_one_cycle letter %0d out_valid got %b want 0", lets[n], out_valid); else pass_cnt++;
    end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    int n_in = 0, n_out = 0, cyc = 0, first = -1, last = -1;
    logic [W:0] e;
    sb.delete();
    while ((n_in < 26 || sb.size() > 0) && cyc < 200) begin
      in_valid = (n_in < 26); in_letter = W'(n_in + 1); out_ready = 1'b1; #1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk_cnt++; $display("FAIL b2b_unexpected_output got %0d want none", out_letter);
        end else begin
          e = sb.pop_front();
          chk_cnt++; if (out_letter !== e[W-1:0]) $display("FAIL b2b_letter got %0d want %0d", out_letter, e[W-1:0]); else pass_cnt++;
        end
        if (first < 0) first = cyc;
        last = cyc; n_out++;
      end
      if (in_valid && in_ready) begin
        sb.push_back({1'b0, inv_of(n_in + 1)});
        n_in++;
      end
      @(posedge clk); @(negedge clk); cyc++;
    end
    in_valid = 1'b0;
    chk_cnt++; if (cyc >= 200) $display("FAIL b2b_timeout got %0d cycles want <200", cyc); else pass_cnt++;
    chk_cnt++; if (n_out != 26) $display("FAIL b2b_count got %0d want 26", n_out); else pass_cnt++;
    chk_cnt++; if (last - first + 1 != 26) $display("FAIL b2b_contiguous got span %0d want 26", last - first + 1); else pass_cnt++;
  endtask

  task automatic test_roundtrip();
    int n_in = 0, n_out = 0, cyc = 0;
    logic [W:0] e;
    sb.delete();
    while ((n_in < 26 || sb.size() > 0) && cyc < 400) begin
      in_valid  = (n_in < 26) && ($urandom_range(0, 3) != 0);
      in_letter = W'(fwd[(n_in < 26) ? n_in + 1 : 26]);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk_cnt++; $display("FAIL rt_unexpected_output got %0d want none", out_letter);
        end else begin
          e = sb.pop_front();
          chk_cnt++; if (out_letter !== e[W-1:0]) $display("FAIL rt_letter got %0d want %0d", out_letter, e[W-1:0]); else pass_cnt++;
        end
        n_out++;
      end
      if (in_valid && in_ready) begin
        sb.push_back({1'b0, W'(n_in + 1)});
        n_in++;
      end
      @(posedge clk); @(negedge clk); cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk_cnt++; if (n_out != 26) $display("FAIL rt_count got %0d want 26", n_out); else pass_cnt++;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_letter = W'(3); out_ready = 1'b0; #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_first_ready got %b want 1", in_ready); else pass_cnt++;
    @(posedge clk); @(negedge clk);
    in_letter = W'(4);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid cyc %0d got %b want 1", c, out_valid); else pass_cnt++;
      chk_cnt++; if (out_letter !== W'(24)) $display("FAIL bp_hold_letter cyc %0d got %0d want 24", c, out_letter); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cyc %0d got %b want 0", c, in_ready); else pass_cnt++;
      @(posedge clk); @(negedge clk);
    end
    out_ready = 1'b1; #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", in_ready); else pass_cnt++;
    chk_cnt++; if (out_letter !== W'(24)) $display("FAIL bp_drain_letter got %0d want 24", out_letter); else pass_cnt++;
    @(posedge clk); @(negedge clk); in_valid = 1'b0; #1;
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_reload_valid got %b want 1", out_valid); else pass_cnt++;
    chk_cnt++; if (out_letter !== W'(12)) $display("FAIL bp_reload_letter got %0d want 12", out_letter); else pass_cnt++;
    @(posedge clk); @(negedge clk); #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_final_drain got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_letter !== W'(12)) $display("FAIL bp_keep_letter got %0d want 12", out_letter); else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    int bad [2] = '{0, 31};
    logic [W:0] e;
    for (int n = 0; n < 2; n++) begin
      in_valid = 1'b1; in_letter = W'(bad[n]); out_ready = 1'b1; #1;
      if (in_valid && in_ready) sb.push_back({ERR_OOR, {W{1'b0}}});
      @(posedge clk); @(negedge clk); in_valid = 1'b0; #1;
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL oor_valid in %0d got %b want 1", bad[n], out_valid); else pass_cnt++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk_cnt++; if (out_letter !== e[W-1:0]) $display("FAIL oor_letter in %0d got %0d want %0d", bad[n], out_letter, e[W-1:0]); else pass_cnt++;
        chk_cnt++; if (err !== e[W]) $display("FAIL oor_err in %0d got %b want %b", bad[n], err, e[W]); else pass_cnt++;
      end
      @(posedge clk); @(negedge clk);
    end
    // a following in-range lookup must clear the flag
    in_valid = 1'b1; in_letter = W'(7); #1;
    @(posedge clk); @(negedge clk); in_valid = 1'b0; #1;
    chk_cnt++; if (out_letter !== inv_of(7)) $display("FAIL oor_recover_letter got %0d want %0d", out_letter, inv_of(7)); else pass_cnt++;
    chk_cnt++; if (err !== 1'b0) $display("FAIL oor_recover_err got %b want 0", err); else pass_cnt++;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_mid_reset();
    in_valid = 1'b1; in_letter = W'(5); out_ready = 1'b0;
    @(posedge clk); @(negedge clk); in_valid = 1'b0; #1;
    chk_cnt++; if (out_valid !== 1'b1 || out_letter !== inv_of(5)) $display("FAIL mr_pending got %b/%0d want 1/%0d", out_valid, out_letter, inv_of(5)); else pass_cnt++;
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk); rst_n = 1'b1; out_ready = 1'b1; #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL mr_out_valid got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (init_done !== 1'b0) $display("FAIL mr_init_done got %b want 0", init_done); else pass_cnt++;
    for (int e = 1; e <= 26; e++) begin
      @(posedge clk); @(negedge clk); #1;
      chk_cnt++; if (init_done !== (e == 26)) $display("FAIL mr_rebuild_edge%0d got %b want %b", e, init_done, (e == 26)); else pass_cnt++;
    end
    in_valid = 1'b1; in_letter = W'(2);
    @(posedge clk); @(negedge clk); in_valid = 1'b0; #1;
    chk_cnt++; if (out_valid !== 1'b1 || out_letter !== W'(1)) $display("FAIL mr_lookup got %b/%0d want 1/1", out_valid, out_letter); else pass_cnt++;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_letter = '0; out_ready = 1'b1;
    test_reset();
    test_lookup();
    test_back_to_back();
    test_roundtrip();
    test_backpressure();
    test_out_of_range();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
